// File: rtl/pll_clk_div.sv
// Multi-channel clock-enable divider gated by a qualified PLL lock, with one
// shadowed divisor update port. Define PLL_DIV_PS_EN to add phase stepping.
module pll_clk_div #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 8,
  parameter int LOCK_WAIT   = 16
) (
  input  logic              clkin,
  input  logic              rst_n,
  input  logic              lock_in,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [2:0]        cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              ps_pulse,
  input  logic [2:0]        ps_ch,
  input  logic              ps_dir,
  output logic [NUM_CH-1:0] ce_out,
  output logic [NUM_CH-1:0] div_out,
  output logic              locked_out
);

  localparam int LCW = $clog2(LOCK_WAIT + 1);

  logic              sync1, sync2;
  logic [LCW-1:0]    lock_cnt;
  logic              locked_nxt;
  logic              run;

  logic [DIV_W-1:0]  div_q   [NUM_CH];
  logic [DIV_W-1:0]  cnt_q   [NUM_CH];
  logic [DIV_W-1:0]  cnt_nxt [NUM_CH];
  logic [DIV_W-1:0]  div_nxt [NUM_CH];
  logic [DIV_W:0]    step    [NUM_CH];
  logic [NUM_CH-1:0] wrap, apply_ch, dv_nxt;

  logic              sh_pend;
  logic [2:0]        sh_ch;
  logic [DIV_W-1:0]  sh_div;
  logic              sh_ch_ok;
  logic              sh_apply;

  assign run        = locked_out & sync2;
  assign locked_nxt = sync2 & (locked_out | (lock_cnt == LCW'(LOCK_WAIT - 1)));
  assign cfg_ready  = ~sh_pend;
  assign sh_ch_ok   = int'(sh_ch) < NUM_CH;
  // A discarded (out-of-range) update, or any update while unlocked, retires at once.
  assign sh_apply   = sh_pend & (~locked_out | ~sh_ch_ok | (|apply_ch));

`ifdef PLL_DIV_PS_EN
  logic [NUM_CH-1:0] ps_hit;
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ps_hit[i] = run & ps_pulse & (int'(ps_ch) == i);
    end
  end
`else
  logic ps_unused;
  assign ps_unused = ^{ps_pulse, ps_ch, ps_dir};
`endif

  // NOTE: every always_comb output is given a value before any conditional
  // override, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      step[i] = {1'b0, cnt_q[i]} + (DIV_W + 1)'(1);
`ifdef PLL_DIV_PS_EN
      if (ps_hit[i]) begin
        step[i] = ps_dir ? {1'b0, cnt_q[i]} + (DIV_W + 1)'(2) : {1'b0, cnt_q[i]};
      end
`endif
      wrap[i]     = run & (step[i] >= {1'b0, div_q[i]});
      cnt_nxt[i]  = '0;
      if (run) begin
        cnt_nxt[i] = wrap[i] ? DIV_W'(step[i] - {1'b0, div_q[i]}) : step[i][DIV_W-1:0];
      end
      // Overshoot past the wrap is 0 or 1, already legal for any new divisor >= 2.
      apply_ch[i] = sh_pend & (int'(sh_ch) == i) & (~locked_out | wrap[i]);
      div_nxt[i]  = apply_ch[i] ? sh_div : div_q[i];
      dv_nxt[i]   = locked_nxt & (cnt_nxt[i] < (div_nxt[i] >> 1));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      lock_cnt   <= '0;
      locked_out <= 1'b0;
      ce_out     <= '0;
      div_out    <= '0;
      sh_pend    <= 1'b0;
      sh_ch      <= '0;
      sh_div     <= '0;
      // NOTE: the per-channel arrays are real state that must come up at the
      // default divisor, so they are reset element by element.
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        div_q[i] <= DIV_W'(DEFAULT_DIV);
      end
    end else begin
      sync1      <= lock_in;
      sync2      <= sync1;
      locked_out <= locked_nxt;
      if (!sync2) begin
        lock_cnt <= '0;
      end else if (!locked_out) begin
        lock_cnt <= lock_cnt + LCW'(1);
      end
      ce_out  <= wrap;
      div_out <= dv_nxt;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_nxt[i];
        div_q[i] <= div_nxt[i];
      end
      if (sh_apply) begin
        sh_pend <= 1'b0;
      end else if (cfg_valid && cfg_ready) begin
        sh_pend <= 1'b1;
        sh_ch   <= cfg_ch;
        sh_div  <= (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;
      end
    end
  end

endmodule

// File: tb/tb_pll_clk_div.sv
// Scoreboard bench for pll_clk_div: expected ce periods and high times are
// queued by the stimulus and retired by a monitor on each ce_out pulse.
module tb_pll_clk_div;

  localparam int NUM_CH = 4;
  localparam int DIV_W  = 8;

  logic              clkin = 1'b0;
  logic              rst_n;
  logic              lock_in;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [2:0]        cfg_ch;
  logic [DIV_W-1:0]  cfg_div;
  logic              ps_pulse;
  logic [2:0]        ps_ch;
  logic              ps_dir;
  logic [NUM_CH-1:0] ce_out;
  logic [NUM_CH-1:0] div_out;
  logic              locked_out;

  pll_clk_div #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEFAULT_DIV(8), .LOCK_WAIT(16)) dut (
    .clkin(clkin), .rst_n(rst_n), .lock_in(lock_in),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .ps_pulse(ps_pulse), .ps_ch(ps_ch), .ps_dir(ps_dir),
    .ce_out(ce_out), .div_out(div_out), .locked_out(locked_out)
  );

  always #5 clkin = ~clkin;

  typedef struct {
    int ch;
    int period;
    int high;
    bit chk;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   last_ce [NUM_CH];
  int   hi_cnt  [NUM_CH];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic push(input int ch, input int period, input int high, input bit chk);
    exp_t e;
    e.ch = ch; e.period = period; e.high = high; e.chk = chk;
    exp_q.push_back(e);
  endtask

  // Monitor: measures period and div_out high time between ce pulses.
  initial begin
    for (int i = 0; i < NUM_CH; i++) begin
      last_ce[i] = 0;
      hi_cnt[i]  = 0;
    end
    forever begin
      @(negedge clkin);
      cyc++;
      for (int i = 0; i < NUM_CH; i++) begin
        if (ce_out[i]) begin
          if (exp_q.size() > 0 && exp_q[0].ch == i) begin
            mon_e = exp_q.pop_front();
            if (mon_e.chk) begin
              check($sformatf("ch%0d_period", i), cyc - last_ce[i], mon_e.period);
              check($sformatf("ch%0d_high", i), hi_cnt[i], mon_e.high);
            end
          end
          last_ce[i] = cyc;
          hi_cnt[i]  = div_out[i] ? 1 : 0;
        end else if (div_out[i]) begin
          hi_cnt[i]++;
        end
      end
    end
  end

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      @(negedge clkin);
      n++;
    end
    if (exp_q.size() > 0) begin
      timeout_fail(name);
      exp_q.delete();
    end
  endtask

  task automatic wait_ce(input int ch);
    int n = 0;
    @(negedge clkin);
    while (!ce_out[ch] && n < 100) begin
      @(negedge clkin);
      n++;
    end
    if (!ce_out[ch]) timeout_fail("wait_ce");
  endtask

  // Counts rising edges until locked_out; caller starts just after an edge.
  task automatic count_lock(input int start, output int n);
    n = start;
    while (!locked_out && n < 100) begin
      @(posedge clkin);
      #1;
      n++;
    end
  endtask

  initial begin
    int n;
    int ok;
    int first [NUM_CH];
    rst_n = 1'b0; lock_in = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
    ps_pulse = 1'b0; ps_ch = '0; ps_dir = 1'b0;

    repeat (3) @(posedge clkin);
    @(negedge clkin);
    check("rst_ce", int'(ce_out), 0);
    check("rst_div", int'(div_out), 0);
    check("rst_locked", int'(locked_out), 0);
    check("rst_cfg_ready", int'(cfg_ready), 1);

    @(posedge clkin); #1 rst_n = 1'b1;
    @(posedge clkin); #1 lock_in = 1'b1;
    count_lock(0, n);
    check("lock_latency", n, 18);

    push(0, 0, 0, 1'b0);
    repeat (3) push(0, 8, 4, 1'b1);
    wait_drain("default_div");

    // Divisor 5 on channel 1, issued at cnt=2.
    wait_ce(1);
    @(posedge clkin); @(posedge clkin); #1;
    cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_div = 8'd5;
    push(1, 8, 4, 1'b1);
    repeat (3) push(1, 5, 2, 1'b1);
    @(posedge clkin); #1 cfg_valid = 1'b0;
    ok = 1; n = 0;
    @(negedge clkin);
    while (!ce_out[1] && n < 20) begin
      if (cfg_ready) ok = 0;
      @(negedge clkin);
      n++;
    end
    check("cfg_busy_until_wrap", ok, 1);
    check("cfg_ready_after_wrap", int'(cfg_ready), 1);
    wait_drain("div5");

    // Divisor 0 clamps to 2.
    wait_ce(2);
    @(posedge clkin); #1;
    cfg_valid = 1'b1; cfg_ch = 3'd2; cfg_div = 8'd0;
    push(2, 8, 4, 1'b1);
    repeat (3) push(2, 2, 1, 1'b1);
    @(posedge clkin); #1 cfg_valid = 1'b0;
    wait_drain("div0");

    // Out-of-range channel: handshake retires, no period changes.
    wait_ce(0);
    @(posedge clkin); #1;
    cfg_valid = 1'b1; cfg_ch = 3'd7; cfg_div = 8'd3;
    @(posedge clkin); #1 cfg_valid = 1'b0;
    @(negedge clkin);
    check("cfg7_busy", int'(cfg_ready), 0);
    @(negedge clkin);
    check("cfg7_ready", int'(cfg_ready), 1);
    repeat (2) push(0, 8, 4, 1'b1);
    push(1, 5, 2, 1'b1);
    push(2, 2, 1, 1'b1);
    push(3, 8, 4, 1'b1);
    wait_drain("cfg7");

`ifdef PLL_DIV_PS_EN
    wait_ce(0);
    repeat (2) @(posedge clkin);
    #1 ps_ch = 3'd0; ps_dir = 1'b0; ps_pulse = 1'b1;
    push(0, 9, 5, 1'b1);
    push(0, 8, 4, 1'b1);
    @(posedge clkin); #1 ps_pulse = 1'b0;
    wait_drain("retard");

    wait_ce(0);
    repeat (6) @(posedge clkin);
    #1 ps_ch = 3'd0; ps_dir = 1'b1; ps_pulse = 1'b1;
    push(0, 7, 4, 1'b1);
    push(0, 8, 4, 1'b1);
    @(posedge clkin); #1 ps_pulse = 1'b0;
    wait_drain("advance");

    wait_ce(0);
    repeat (3) @(posedge clkin);
    #1 ps_ch = 3'd7; ps_dir = 1'b0; ps_pulse = 1'b1;
    push(0, 8, 4, 1'b1);
    @(posedge clkin); #1 ps_pulse = 1'b0;
    wait_drain("ps_bad_ch");
`else
    wait_ce(0);
    repeat (2) @(posedge clkin);
    #1 ps_ch = 3'd0; ps_dir = 1'b0; ps_pulse = 1'b1;
    repeat (2) push(0, 8, 4, 1'b1);
    @(posedge clkin); #1 ps_pulse = 1'b0;
    wait_drain("ps_ignored");
`endif

    // One-cycle lock drop, with an update while unlocked.
    @(posedge clkin); #1 lock_in = 1'b0;
    @(posedge clkin); #1 lock_in = 1'b1;
    @(posedge clkin); @(posedge clkin);
    @(negedge clkin);
    check("drop_ce", int'(ce_out), 0);
    check("drop_div", int'(div_out), 0);
    check("drop_locked", int'(locked_out), 0);
    @(posedge clkin); #1;
    cfg_valid = 1'b1; cfg_ch = 3'd3; cfg_div = 8'd3;
    @(posedge clkin); #1 cfg_valid = 1'b0;
    @(negedge clkin);
    check("unlocked_cfg_busy", int'(cfg_ready), 0);
    @(posedge clkin);
    @(negedge clkin);
    check("unlocked_cfg_ready", int'(cfg_ready), 1);
    count_lock(5, n);
    check("relock_latency", n, 18);

    for (int i = 0; i < NUM_CH; i++) first[i] = -1;
    @(negedge clkin);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clkin);
      for (int i = 0; i < NUM_CH; i++) begin
        if (ce_out[i] && first[i] < 0) first[i] = c;
      end
    end
    check("restart_ce0", first[0], 8);
    check("restart_ce1", first[1], 5);
    check("restart_ce2", first[2], 2);
    check("restart_ce3", first[3], 3);
    repeat (2) push(3, 3, 1, 1'b1);
    wait_drain("div3_after_relock");

    // Mid-run reset restores defaults and restarts qualification.
    @(posedge clkin); #1 rst_n = 1'b0;
    @(negedge clkin);
    check("rst2_locked", int'(locked_out), 0);
    check("rst2_cfg_ready", int'(cfg_ready), 1);
    check("rst2_ce", int'(ce_out), 0);
    @(posedge clkin); #1 rst_n = 1'b1;
    count_lock(0, n);
    check("rst2_lock_latency", n, 18);
    push(1, 0, 0, 1'b0);
    push(1, 8, 4, 1'b1);
    push(3, 8, 4, 1'b1);
    wait_drain("rst2_defaults");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
